// File: rtl/aclint_pkg.sv
// Shared constants for the APB machine timer / software interrupt block.
// Register byte offsets and reset values used by aclint_apb.
package aclint_pkg;

    // Byte offsets of the 64-bit-aligned register slots.
    localparam logic [15:0] ACLINT_MSIP     = 16'h0000;
    localparam logic [15:0] ACLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] ACLINT_MTIME    = 16'hBFF8;
    localparam logic [15:0] ACLINT_SSIP     = 16'hC000;

    // mtimecmp resets to the largest value so no timer interrupt fires
    // until software programs a compare value.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtime_prescaler.sv
// Divider for the mtime time base: emits a one-cycle tick every TICK_DIV
// clock cycles. The count runs 0..TICK_DIV-1 and the tick is asserted while
// the count sits at its terminal value.
module mtime_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    // With TICK_DIV=1 a single-bit counter that never leaves 0 keeps the
    // tick permanently asserted.
    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o  = (count_q == LAST);
    assign count_d = tick_o ? '0 : count_q + CW'(1);

    // Divider counter, wraps to 0 on the tick edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aclint_apb.sv
// APB-attached machine timer and software interrupt source.
// Owns mtime, mtimecmp, msip and (optionally) ssip; drives the timer and
// software interrupt-pending bits sampled by the hart's MIP register.
// Optional feature macro: ACLINT_SSWI_EN enables the ssip register at 0xC000
// and the SSwInt output; without it 0xC000 is unmapped and SSwInt is 0.
module aclint_apb
    import aclint_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [15:0]       PADDR,
    input  logic [XLEN-1:0]   PWDATA,
    input  logic [XLEN/8-1:0] PSTRB,
    output logic [XLEN-1:0]   PRDATA,
    output logic              PREADY,
    output logic              MTimerInt,
    output logic              MSwInt,
    output logic              SSwInt
);

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        msip_q;
    logic        msip_d;
    logic        mtimer_q;
    logic        tick;

    logic        wr_en;
    logic        rd_en;
    logic [15:0] reg_addr;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64;
    logic [63:0] next_time;
    logic [63:0] rdata64;
    logic        sel_mtime;
    logic        sel_mtimecmp;
    logic        sel_msip;
    logic        unused_paddr_lsb;

    mtime_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign PREADY = 1'b1;
    assign wr_en  = PSEL & PENABLE & PWRITE;
    assign rd_en  = PSEL & PENABLE & ~PWRITE;

    // Registers are decoded on their 64-bit slot; the word/byte offset below
    // that only matters for the 32-bit bus half select.
    assign reg_addr         = {PADDR[15:3], 3'b000};
    assign unused_paddr_lsb = ^PADDR[2:0];

    assign sel_mtime    = (reg_addr == ACLINT_MTIME);
    assign sel_mtimecmp = (reg_addr == ACLINT_MTIMECMP);
    assign sel_msip     = (reg_addr == ACLINT_MSIP);

    // Lift the bus write onto a 64-bit data/strobe view so the register
    // update logic is width independent.
    generate
        if (XLEN == 64) begin : g_bus64
            assign wdata64 = PWDATA;
            assign wstrb64 = PSTRB;
        end else begin : g_bus32
            assign wdata64 = {PWDATA, PWDATA};
            assign wstrb64 = PADDR[2] ? {PSTRB, 4'b0000} : {4'b0000, PSTRB};
        end
    endgenerate

    // Time base after this edge if untouched by software. Written bytes
    // replace bytes of this value; carries never reach a written byte.
    assign next_time = mtime_q + {63'b0, tick};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_merge
            assign mtime_d[8*gi +: 8] = (wr_en & sel_mtime & wstrb64[gi])
                                      ? wdata64[8*gi +: 8]
                                      : next_time[8*gi +: 8];
            assign mtimecmp_d[8*gi +: 8] = (wr_en & sel_mtimecmp & wstrb64[gi])
                                         ? wdata64[8*gi +: 8]
                                         : mtimecmp_q[8*gi +: 8];
        end
    endgenerate

    assign msip_d = (wr_en & sel_msip & wstrb64[0]) ? wdata64[0] : msip_q;

    // Register file and registered timer compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtimer_q   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtimer_q   <= (mtime_q >= mtimecmp_q);
        end
    end

    assign MTimerInt = mtimer_q;
    assign MSwInt    = msip_q;

`ifdef ACLINT_SSWI_EN
    logic ssip_q;
    logic ssip_d;

    assign ssip_d = (wr_en & (reg_addr == ACLINT_SSIP) & wstrb64[0])
                  ? wdata64[0] : ssip_q;

    // Supervisor software interrupt pending bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ssip_q <= 1'b0;
        end else begin
            ssip_q <= ssip_d;
        end
    end

    assign SSwInt = ssip_q;
`else
    assign SSwInt = 1'b0;
`endif

    // Read mux from current register values; no bypass of a same-cycle write.
    always_comb begin
        rdata64 = '0;
        if (rd_en) begin
            case (reg_addr)
                ACLINT_MSIP:     rdata64 = {63'b0, msip_q};
                ACLINT_MTIMECMP: rdata64 = mtimecmp_q;
                ACLINT_MTIME:    rdata64 = mtime_q;
`ifdef ACLINT_SSWI_EN
                ACLINT_SSIP:     rdata64 = {63'b0, ssip_q};
`endif
                default:         rdata64 = '0;
            endcase
        end
    end

    generate
        if (XLEN == 64) begin : g_rd64
            assign PRDATA = rdata64;
        end else begin : g_rd32
            assign PRDATA = PADDR[2] ? rdata64[63:32] : rdata64[31:0];
        end
    endgenerate

endmodule

// File: tb/tb_aclint_apb.sv
// Testbench for aclint_apb. Two instances: index 0 is XLEN=64/TICK_DIV=1,
// index 1 is XLEN=32/TICK_DIV=4. A reference model tracks the architectural
// register contents; read expectations are queued when a read is issued and
// a negedge monitor pops and compares them, and also checks the interrupt
// outputs against the model every cycle.
module tb_aclint_apb;

    localparam bit SSWI =
`ifdef ACLINT_SSWI_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        psel[2];
    logic        penable[2];
    logic        pwrite[2];
    logic [15:0] paddr[2];
    logic [63:0] pwdata[2];
    logic [7:0]  pstrb[2];

    logic [63:0] prdata0;
    logic [31:0] prdata1;
    logic        pready0, pready1;
    logic        mti0, mti1, msi0, msi1, ssi0, ssi1;

    int checks = 0;
    int errors = 0;

    // Reference model state (starts at reset values).
    logic [63:0] m_mtime[2] = '{64'd0, 64'd0};
    logic [63:0] m_cmp[2]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic        m_msip[2]  = '{1'b0, 1'b0};
    logic        m_ssip[2]  = '{1'b0, 1'b0};
    logic        m_tmr[2]   = '{1'b0, 1'b0};
    int          m_cnt[2]   = '{0, 0};

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    aclint_apb #(.XLEN(64), .TICK_DIV(1)) dut0 (
        .clk(clk), .reset(rst),
        .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata0), .PREADY(pready0),
        .MTimerInt(mti0), .MSwInt(msi0), .SSwInt(ssi0)
    );

    aclint_apb #(.XLEN(32), .TICK_DIV(4)) dut1 (
        .clk(clk), .reset(rst),
        .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1][31:0]), .PSTRB(pstrb[1][3:0]),
        .PRDATA(prdata1), .PREADY(pready1),
        .MTimerInt(mti1), .MSwInt(msi1), .SSwInt(ssi1)
    );

    // ---------------- reference model ----------------
    function automatic int td(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Byte enables in 64-bit register terms.
    function automatic logic [7:0] wmask(input int d);
        if (d == 0) return pstrb[0];
        return paddr[1][2] ? {pstrb[1][3:0], 4'h0} : {4'h0, pstrb[1][3:0]};
    endfunction

    function automatic logic [63:0] wdat(input int d);
        if (d == 0) return pwdata[0];
        return {pwdata[1][31:0], pwdata[1][31:0]};
    endfunction

    function automatic bit wr_at(input int d, input logic [15:0] base);
        return psel[d] && penable[d] && pwrite[d] && ((paddr[d] & 16'hFFF8) == base);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] oldv, input logic [63:0] newv,
                                          input logic [7:0] m);
        logic [63:0] r = oldv;
        for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = newv[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] nxt_mtime(input int d);
        logic [63:0] n = m_mtime[d] + ((m_cnt[d] == td(d) - 1) ? 64'd1 : 64'd0);
        if (wr_at(d, 16'hBFF8)) n = merge(n, wdat(d), wmask(d));
        return n;
    endfunction

    function automatic logic [63:0] nxt_cmp(input int d);
        if (wr_at(d, 16'h4000)) return merge(m_cmp[d], wdat(d), wmask(d));
        return m_cmp[d];
    endfunction

    function automatic logic nxt_bit(input int d, input logic [15:0] base, input logic cur);
        logic [7:0]  m = wmask(d);
        logic [63:0] w = wdat(d);
        return (wr_at(d, base) && m[0]) ? w[0] : cur;
    endfunction

    function automatic logic [63:0] exp_rd(input int d);
        logic [63:0] v;
        case (paddr[d] & 16'hFFF8)
            16'h0000: v = {63'b0, m_msip[d]};
            16'h4000: v = m_cmp[d];
            16'hBFF8: v = m_mtime[d];
            16'hC000: v = SSWI ? {63'b0, m_ssip[d]} : 64'd0;
            default:  v = 64'd0;
        endcase
        if (d == 1) v = paddr[1][2] ? {32'b0, v[63:32]} : {32'b0, v[31:0]};
        return v;
    endfunction

    // Model advances one clock: reset wins, otherwise apply tick and writes.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_mtime[d] <= 64'd0;
                m_cmp[d]   <= 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[d]  <= 1'b0;
                m_ssip[d]  <= 1'b0;
                m_tmr[d]   <= 1'b0;
                m_cnt[d]   <= 0;
            end else begin
                m_cnt[d]   <= (m_cnt[d] == td(d) - 1) ? 0 : m_cnt[d] + 1;
                m_mtime[d] <= nxt_mtime(d);
                m_cmp[d]   <= nxt_cmp(d);
                m_msip[d]  <= nxt_bit(d, 16'h0000, m_msip[d]);
                m_ssip[d]  <= SSWI ? nxt_bit(d, 16'hC000, m_ssip[d]) : 1'b0;
                m_tmr[d]   <= (m_mtime[d] >= m_cmp[d]);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic orphan(input string name);
        checks++;
        errors++;
        $display("FAIL %s: read seen with no queued expectation at %0t", name, $time);
    endtask

    // Monitor: pop expected read data when a read access is presented.
    always @(negedge clk) begin
        if (psel[0] && penable[0] && !pwrite[0]) begin
            if (q0.size() == 0) orphan("rd0");
            else check("rd0", prdata0, q0.pop_front());
        end else begin
            check("idle_prdata0", prdata0, 64'd0);
        end
        if (psel[1] && penable[1] && !pwrite[1]) begin
            if (q1.size() == 0) orphan("rd1");
            else check("rd1", {32'b0, prdata1}, q1.pop_front());
        end else begin
            check("idle_prdata1", {32'b0, prdata1}, 64'd0);
        end
        check("pready0", {63'b0, pready0}, 64'd1);
        check("pready1", {63'b0, pready1}, 64'd1);
        check("mti0", {63'b0, mti0}, {63'b0, m_tmr[0]});
        check("mti1", {63'b0, mti1}, {63'b0, m_tmr[1]});
        check("msi0", {63'b0, msi0}, {63'b0, m_msip[0]});
        check("msi1", {63'b0, msi1}, {63'b0, m_msip[1]});
        check("ssi0", {63'b0, ssi0}, {63'b0, m_ssip[0]});
        check("ssi1", {63'b0, ssi1}, {63'b0, m_ssip[1]});
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer; want >= 0 aligns the access cycle to that prescaler count.
    task automatic apb(input int d, input bit wr, input logic [15:0] a,
                       input logic [63:0] wd, input logic [7:0] st, input int want);
        int guard = 0;
        if (want >= 0) begin
            while (((m_cnt[d] + 1) % td(d)) != want) begin
                if (guard++ > 8) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_align: count %0d never reached %0d", m_cnt[d], want);
                    break;
                end
                idle(1);
            end
        end
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        pstrb[d]   = st;
        idle(1);
        penable[d] = 1'b1;
        if (!wr) begin
            if (d == 0) q0.push_back(exp_rd(0));
            else        q1.push_back(exp_rd(1));
            $display("dut%0d read  addr=%h expect=%h", d, a, exp_rd(d));
        end else begin
            $display("dut%0d write addr=%h data=%h strb=%h", d, a, wd, st);
        end
        idle(1);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b0;
        pstrb[d]   = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] alist[8];
        alist = '{16'h0000, 16'h4000, 16'hBFF8, 16'hC000,
                  16'h0100, 16'h8000, 16'hBFF0, 16'h4008};
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 16'h0; pwdata[d] = 64'h0; pstrb[d] = 8'h0;
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset values and free-running mtime.
        apb(0, 0, 16'h4000, 0, 0, -1);
        apb(0, 0, 16'hBFF8, 0, 0, -1);
        apb(0, 0, 16'hBFF8, 0, 0, -1);
        apb(0, 0, 16'h0000, 0, 0, -1);

        // Timer compare: mtime=10, mtimecmp=20, then raise to 100.
        apb(0, 1, 16'hBFF8, 64'd10, 8'hFF, -1);
        apb(0, 1, 16'h4000, 64'd20, 8'hFF, -1);
        idle(15);
        apb(0, 1, 16'h4000, 64'd100, 8'hFF, -1);
        idle(3);

        // Machine software interrupt set / read back / clear.
        apb(0, 1, 16'h0000, 64'd1, 8'h01, -1);
        apb(0, 0, 16'h0000, 0, 0, -1);
        apb(0, 1, 16'h0000, 64'd0, 8'h01, -1);
        apb(0, 0, 16'h0000, 0, 0, -1);

        // Supervisor software interrupt (or unmapped 0xC000).
        apb(0, 1, 16'hC000, 64'd1, 8'h01, -1);
        apb(0, 0, 16'hC000, 0, 0, -1);
        apb(0, 1, 16'hC000, 64'd0, 8'h01, -1);

        // Reset asserted during the access phase discards the write.
        psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 16'h0000;
        pwdata[0] = 64'd1; pstrb[0] = 8'h01;
        idle(1);
        penable[0] = 1'b1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0; pwrite[0] = 1'b0; pstrb[0] = 8'h0;
        $display("dut0 write addr=0000 aborted by reset");
        idle(2);
        apb(0, 0, 16'h0000, 0, 0, -1);

        // Wrap-around of mtime through the all-ones compare value.
        apb(0, 1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1);
        apb(0, 1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, -1);
        idle(5);
        apb(0, 0, 16'hBFF8, 0, 0, -1);

        // Randomized traffic on the 64-bit instance.
        for (int i = 0; i < 150; i++) begin
            apb(0, 1'($urandom_range(0, 1)),
                alist[$urandom_range(0, 7)] | 16'($urandom_range(0, 7)),
                {$urandom, $urandom}, 8'($urandom), -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Prescaler on the 32-bit instance: low word read over many cycles.
        for (int i = 0; i < 6; i++) begin
            apb(1, 0, 16'hBFF8, 0, 0, -1);
            idle(i % 3);
        end

        // Merge: low-word write on a tick cycle while mtime=0x1_FFFF_FFFF.
        apb(1, 1, 16'hBFFC, 64'h1, 8'h0F, -1);
        apb(1, 1, 16'hBFF8, 64'hFFFF_FFFF, 8'h0F, 0);
        apb(1, 1, 16'hBFF8, 64'h10, 8'h0F, 3);
        apb(1, 0, 16'hBFFC, 0, 0, -1);
        apb(1, 0, 16'hBFF8, 0, 0, -1);

        // Interrupts through the 32-bit bus.
        apb(1, 1, 16'h4004, 64'h2, 8'h0F, -1);
        apb(1, 1, 16'h4000, 64'h18, 8'h0F, -1);
        idle(30);
        apb(1, 1, 16'h0000, 64'h1, 8'h01, -1);
        apb(1, 1, 16'hC000, 64'h1, 8'h01, -1);
        apb(1, 0, 16'hC000, 0, 0, -1);
        apb(1, 0, 16'h0004, 0, 0, -1);

        // Randomized traffic on the 32-bit instance.
        for (int i = 0; i < 100; i++) begin
            apb(1, 1'($urandom_range(0, 1)),
                alist[$urandom_range(0, 7)] | 16'($urandom_range(0, 7)),
                {32'h0, $urandom}, 8'($urandom_range(0, 15)), -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        idle(4);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d queued reads never observed", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
